// File: rtl/register_file.sv
// 32 x WIDTH architectural register file: one write port, two combinational read ports
// with same-cycle write forwarding, and a one-register-per-cycle clear sweep.
module register_file #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regWrite,
    input  logic [4:0]       writeSel,
    input  logic [WIDTH-1:0] writeData,
    input  logic [4:0]       readSel1,
    input  logic [4:0]       readSel2,
    output logic [WIDTH-1:0] readData1,
    output logic [WIDTH-1:0] readData2,
    input  logic             clrReq,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state;
    logic [4:0]       ptr;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] write_en;
    logic             fwd1;
    logic             fwd2;

    // One-hot write decode; bit 0 is forced off so r0 never leaves zero.
    always_comb begin
        write_en = '0;
        if (regWrite && state == IDLE) begin
            write_en[writeSel] = 1'b1;
        end
        write_en[0] = 1'b0;
    end

    // NOTE: the storage array is reset here on purpose; the file must read all-zero
    // after reset, which a RAM macro without reset could not provide.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
            state <= IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    for (int k = 1; k < DEPTH; k++) begin
                        if (write_en[k]) begin
                            regs[k] <= writeData;
                        end
                    end
                    if (clrReq) begin
                        state <= CLEAR;
                        ptr   <= 5'd1;
                    end
                end
                CLEAR: begin
                    regs[ptr] <= '0;
                    if (ptr == 5'(DEPTH - 1)) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    // Forwarding presents the value that will commit at the coming edge.
    assign fwd1 = regWrite && (state == IDLE) && (writeSel != 5'd0) && (writeSel == readSel1);
    assign fwd2 = regWrite && (state == IDLE) && (writeSel != 5'd0) && (writeSel == readSel2);

    always_comb begin
        readData1 = '0;
        readData2 = '0;
        if (fwd1) begin
            readData1 = writeData;
        end else if (readSel1 != 5'd0) begin
            readData1 = regs[readSel1];
        end
        if (fwd2) begin
            readData2 = writeData;
        end else if (readSel2 != 5'd0) begin
            readData2 = regs[readSel2];
        end
    end

    assign busy = (state == CLEAR);

endmodule

// File: doc/register_file.md
# register_file

- Architectural register file for the single-cycle datapath: 32 registers of 32 bits.
- Write port: a one-hot decoded write enable, selected by the 5-bit destination index.
- Read ports: two 5-bit-selected read ports, feeding the ALU operand and store-data paths.
- Also provides same-cycle write-to-read forwarding and a sequenced clear engine that zeroes the file one register per cycle under a busy flag.

## Interface
- WIDTH, 32, data width of each register and of all data ports.
- DEPTH, 32, register count; fixed at 32 (index width 5).
- Reset: one clock; reset is synchronous and active-high. Ports are named clk and rst.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- regWrite  in  1  write enable for writeData
- writeSel  in  5  destination register index
- writeData  in  WIDTH  data to write
- readSel1  in  5  read port 1 index
- readSel2  in  5  read port 2 index
- readData1  out  WIDTH  read port 1 data (combinational)
- readData2  out  WIDTH  read port 2 data (combinational)
- clrReq  in  1  request a full-file clear sweep
- busy  out  1  high while the clear sweep runs

## Operation

**Storage and write**
- Storage: reg[0..31], each WIDTH bits.
- Write enable is internally decoded one-hot: bit k is set when writeSel==k, gated by regWrite and by state==IDLE.
- reg[0] is hardwired zero: writes to index 0 are discarded and reads of index 0 return 0.

**Read**
- readDataN = reg[readSelN], with one exception: forwarding.
- Forwarding condition: regWrite=1, state==IDLE, writeSel!=0 and writeSel==readSelN.
- When it holds, readDataN = writeData (the value that commits at the coming edge).
- Forwarding applies independently to each port; both ports may forward the same value.

**State machine (IDLE, CLEAR)**
- IDLE, clrReq=1 → CLEAR at the next edge; ptr←1.
  - A write presented in that same cycle still commits.
- CLEAR: each edge does reg[ptr]←0 and ptr←ptr+1.
  - At the edge that clears reg[31], go to IDLE; ptr←0.
- In CLEAR:
  - regWrite is ignored (the write is dropped, not deferred).
  - Forwarding is disabled.
  - clrReq is ignored.
  - Reads return current contents: already-swept registers read 0, the rest hold their old values.
- busy = (state==CLEAR).

**Reset**
- rst=1 at an edge: all reg←0, state←IDLE, ptr←0.
- Reset takes priority over writes and sweep steps.
- Reset mid-sweep aborts the sweep; busy is low the cycle after.

## Timing
- Reset values:
  - busy=0, all registers 0.
  - readData1/readData2 = 0 for any index, unless forwarding is active.
- Write latency:
  - Register updated at the edge where regWrite=1.
  - Visible via forwarding in the same cycle, and from storage on the following cycle.
- Read latency: 0 cycles (combinational from readSelN, regWrite, writeSel and writeData).
- Clear sweep:
  - busy rises the cycle after clrReq is sampled and stays high for exactly 31 cycles (sweeping indices 1..31).
  - First cycle with busy=0 after the sweep: every register reads 0, and writes are accepted in that cycle.
- clrReq held high continuously: a new sweep starts on the first IDLE cycle, so busy drops for exactly one cycle between sweeps.
- Boundary conditions:
  - ptr wraps 31→0 only on the sweep-exit edge.
  - writeSel==readSel1==readSel2==0 with regWrite=1: both reads return 0 and no state changes.

## Test plan
- **Reset:** rst=1 for one edge, then readSel1=5, readSel2=31 → both read 0x00000000, busy=0.
- **Write then read:**
  - Cycle 1: regWrite=1, writeSel=7, writeData=0x0451ABCD, readSel1=7 → readData1=0x0451ABCD (forwarded).
  - Cycle 2: regWrite=0 → readData1 still 0x0451ABCD, from storage.
- **r0 protection:** regWrite=1, writeSel=0, writeData=0xFFFFFFFF, readSel1=0 in the same cycle and the next → readData1=0 both cycles.
- **Dual read:**
  - Write r3=0x1456EDCF, then r30=0x0123AEFD.
  - Then readSel1=3, readSel2=30 → readData1=0x1456EDCF, readData2=0x0123AEFD.
- **Clear sweep:**
  - Load r1, r16, r31 with nonzero values, then pulse clrReq.
  - busy must be high for exactly 31 cycles.
  - regWrite to r16 (0xDEADBEEF) at sweep cycle 5 is dropped.
  - After busy falls, r1, r16 and r31 all read 0.
- **Reset mid-sweep:** start a sweep, assert rst at sweep cycle 10 → busy=0 on the next cycle, all registers read 0, and a write to r4 in the first post-reset cycle commits.
